// File: rtl/frame_buf_sched_pkg.sv
// Shared types and helpers for the triple-buffer frame scheduler.
// Buffer lifecycle states, AXI burst size and buffer base-address arithmetic.
package frame_buf_sched_pkg;

   localparam int unsigned BURST_BYTES = 128;
   localparam int unsigned IDX_W       = 3;

   typedef enum logic [1:0] {
      BUF_FREE    = 2'd0,
      BUF_WRITING = 2'd1,
      BUF_READY   = 2'd2,
      BUF_READING = 2'd3
   } buf_state_t;

   function automatic logic [31:0] buf_base(input logic [IDX_W-1:0] idx,
                                            input logic [31:0]       base,
                                            input logic [31:0]       frame_bytes);
      return base + 32'(idx) * frame_bytes;
   endfunction

endpackage

// File: rtl/frame_buf_pick.sv
// Lowest-index search over the buffer state array for a requested state.
// Purely combinational; o_found is low when no entry matches.
module frame_buf_pick
   import frame_buf_sched_pkg::*;
#(
   parameter int unsigned NBUF = 3
) (
   input  buf_state_t [NBUF-1:0] i_states,
   input  buf_state_t            i_match,
   output logic                  o_found,
   output logic [IDX_W-1:0]      o_idx
);

   localparam int unsigned IW = $clog2(NBUF);

   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      for (int unsigned i = 0; i < NBUF; i++) begin
         if (!o_found && i_states[IW'(i)] == i_match) begin
            o_found = 1'b1;
            o_idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/frame_buf_sched.sv
// Frame buffer scheduler: rotates NBUF DDR frame buffers between writer and reader
// on each vsync rising edge, promoting a buffer only after all its bursts got OKAY.
module frame_buf_sched
   import frame_buf_sched_pkg::*;
#(
   parameter int unsigned NBUF        = 3,
   parameter logic [31:0] BASE        = 32'h2000_0000,
   parameter int unsigned FRAME_BYTES = 6220800
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             vs_i,
   input  logic             en_i,
   input  logic             aw_fire_i,
   input  logic             b_fire_i,
   input  logic [1:0]       bresp_i,
   input  logic             ar_fire_i,
   output logic             wen_o,
   output logic             ren_o,
   output logic [31:0]      wbase_o,
   output logic [31:0]      rbase_o,
   output logic [IDX_W-1:0] wr_idx_o,
   output logic [IDX_W-1:0] rd_idx_o,
   output logic             repeat_o,
   output logic             drop_o,
   output logic             err_o
);

   localparam int unsigned NBURST = FRAME_BYTES / BURST_BYTES;
   localparam int unsigned CW     = $clog2(NBURST + 1);
   localparam int unsigned IW     = $clog2(NBUF);
   localparam logic [CW-1:0] NB   = CW'(NBURST);

   if (NBUF < 3 || NBUF > 8) begin : g_nbuf_chk
      $error("frame_buf_sched: NBUF must be within 3..8");
   end
   if (64'(BASE) + 64'(NBUF) * 64'(FRAME_BYTES) > 64'h1_0000_0000) begin : g_wrap_chk
      $error("frame_buf_sched: buffer region wraps the 32-bit address space");
   end

   buf_state_t [NBUF-1:0] r_state, w_state_mid, w_state_n;
   logic                  r_vs, r_started, r_valid_rd, r_bad, r_err;
   logic [CW-1:0]         r_aw_cnt, r_b_cnt, r_ar_cnt;
   logic [IDX_W-1:0]      r_wr_idx, r_rd_idx;
   logic                  r_wen, r_ren, r_repeat, r_drop;
   logic [31:0]           r_wbase, r_rbase;

   logic                  w_vs_rise, w_complete, w_bad_inc;
   logic [CW-1:0]         w_aw_inc, w_b_inc, w_ar_inc;
   logic [CW-1:0]         w_aw_n, w_b_n, w_ar_n;
   logic                  w_bad_n, w_err_n, w_started_n, w_valid_rd_n;
   logic [IDX_W-1:0]      w_wr_idx_n, w_rd_idx_n;
   logic                  w_repeat_n, w_drop_n, w_wen_n, w_ren_n;
   logic [31:0]           w_wbase_n, w_rbase_n;
   logic                  w_ready_found, w_free_found, w_rdy_found;
   logic [IDX_W-1:0]      w_ready_idx, w_free_idx, w_rdy_idx;

   frame_buf_pick #(.NBUF(NBUF)) u_pick_ready (
      .i_states (r_state),
      .i_match  (BUF_READY),
      .o_found  (w_ready_found),
      .o_idx    (w_ready_idx)
   );

   frame_buf_pick #(.NBUF(NBUF)) u_pick_free (
      .i_states (w_state_mid),
      .i_match  (BUF_FREE),
      .o_found  (w_free_found),
      .o_idx    (w_free_idx)
   );

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NBUF; i++) begin
            r_state[IW'(i)] <= (i == 0) ? BUF_WRITING : BUF_FREE;
         end
         r_vs       <= 1'b0;
         r_started  <= 1'b0;
         r_valid_rd <= 1'b0;
         r_bad      <= 1'b0;
         r_err      <= 1'b0;
         r_aw_cnt   <= '0;
         r_b_cnt    <= '0;
         r_ar_cnt   <= '0;
         r_wr_idx   <= '0;
         r_rd_idx   <= '0;
         r_wen      <= 1'b0;
         r_ren      <= 1'b0;
         r_repeat   <= 1'b0;
         r_drop     <= 1'b0;
         r_wbase    <= BASE;
         r_rbase    <= BASE;
      end else begin
         r_state    <= w_state_n;
         r_vs       <= vs_i;
         r_started  <= w_started_n;
         r_valid_rd <= w_valid_rd_n;
         r_bad      <= w_bad_n;
         r_err      <= w_err_n;
         r_aw_cnt   <= w_aw_n;
         r_b_cnt    <= w_b_n;
         r_ar_cnt   <= w_ar_n;
         r_wr_idx   <= w_wr_idx_n;
         r_rd_idx   <= w_rd_idx_n;
         r_wen      <= w_wen_n;
         r_ren      <= w_ren_n;
         r_repeat   <= w_repeat_n;
         r_drop     <= w_drop_n;
         r_wbase    <= w_wbase_n;
         r_rbase    <= w_rbase_n;
      end
   end

   // Burst counters; fires in the vsync cycle only feed the completion test
   always_comb begin
      w_vs_rise = vs_i & ~r_vs;
      w_aw_inc  = (aw_fire_i && r_aw_cnt < NB) ? r_aw_cnt + CW'(1) : r_aw_cnt;
      w_b_inc   = (b_fire_i && r_b_cnt < r_aw_cnt) ? r_b_cnt + CW'(1) : r_b_cnt;
      w_ar_inc  = (ar_fire_i && r_ar_cnt < NB) ? r_ar_cnt + CW'(1) : r_ar_cnt;
      w_bad_inc = r_bad | (b_fire_i & bresp_i[1]);
      w_complete = (w_b_inc == NB) & ~w_bad_inc;
      w_aw_n    = w_vs_rise ? '0 : w_aw_inc;
      w_b_n     = w_vs_rise ? '0 : w_b_inc;
      w_ar_n    = w_vs_rise ? '0 : w_ar_inc;
      w_bad_n   = w_vs_rise ? 1'b0 : w_bad_inc;
      w_err_n   = r_err | (b_fire_i & bresp_i[1]);
      w_started_n = r_started | w_vs_rise;
   end

   // Retire the written frame, then hand the newest READY frame to the reader
   always_comb begin
      w_state_mid  = r_state;
      w_drop_n     = 1'b0;
      w_repeat_n   = 1'b0;
      w_rd_idx_n   = r_rd_idx;
      w_valid_rd_n = r_valid_rd;
      w_rdy_found  = 1'b0;
      w_rdy_idx    = '0;
      if (w_vs_rise) begin
         if (w_complete) begin
            if (w_ready_found) begin
               w_state_mid[IW'(w_ready_idx)] = BUF_FREE;
               w_drop_n = 1'b1;
            end
            w_state_mid[IW'(r_wr_idx)] = BUF_READY;
            w_rdy_found = 1'b1;
            w_rdy_idx   = r_wr_idx;
         end else begin
            w_state_mid[IW'(r_wr_idx)] = BUF_FREE;
            w_drop_n    = (w_aw_inc != '0);
            w_rdy_found = w_ready_found;
            w_rdy_idx   = w_ready_idx;
         end
         if (w_rdy_found) begin
            if (r_valid_rd) begin
               w_state_mid[IW'(r_rd_idx)] = BUF_FREE;
            end
            w_state_mid[IW'(w_rdy_idx)] = BUF_READING;
            w_rd_idx_n   = w_rdy_idx;
            w_valid_rd_n = 1'b1;
         end else begin
            w_repeat_n = r_valid_rd;
         end
      end
   end

   // Writer takes the lowest free buffer
   always_comb begin
      w_state_n  = w_state_mid;
      w_wr_idx_n = r_wr_idx;
      if (w_vs_rise && w_free_found) begin
         w_state_n[IW'(w_free_idx)] = BUF_WRITING;
         w_wr_idx_n = w_free_idx;
      end
   end

   // Registered engine gates and buffer bases
   always_comb begin
      w_wen_n   = en_i & w_started_n & (w_aw_n < NB);
      w_ren_n   = en_i & w_valid_rd_n & (w_ar_n < NB);
      w_wbase_n = buf_base(w_wr_idx_n, BASE, 32'(FRAME_BYTES));
      w_rbase_n = buf_base(w_rd_idx_n, BASE, 32'(FRAME_BYTES));
   end

   assign wen_o    = r_wen;
   assign ren_o    = r_ren;
   assign wbase_o  = r_wbase;
   assign rbase_o  = r_rbase;
   assign wr_idx_o = r_wr_idx;
   assign rd_idx_o = r_rd_idx;
   assign repeat_o = r_repeat;
   assign drop_o   = r_drop;
   assign err_o    = r_err;

endmodule

// File: tb/tb_frame_buf_sched.sv
// Directed bench for frame_buf_sched with a small frame (8 bursts per frame).
module tb_frame_buf_sched;

   localparam int unsigned NBUF        = 3;
   localparam logic [31:0] BASE        = 32'h2000_0000;
   localparam int unsigned FRAME_BYTES = 1024;
   localparam int          NB          = 8;

   logic        clk_i = 1'b0;
   logic        rst_ni, vs_i, en_i, aw_fire_i, b_fire_i, ar_fire_i;
   logic [1:0]  bresp_i;
   logic        wen_o, ren_o, repeat_o, drop_o, err_o;
   logic [31:0] wbase_o, rbase_o;
   logic [2:0]  wr_idx_o, rd_idx_o;

   int checks   = 0;
   int failures = 0;

   frame_buf_sched #(.NBUF(NBUF), .BASE(BASE), .FRAME_BYTES(FRAME_BYTES)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .vs_i(vs_i), .en_i(en_i),
      .aw_fire_i(aw_fire_i), .b_fire_i(b_fire_i), .bresp_i(bresp_i), .ar_fire_i(ar_fire_i),
      .wen_o(wen_o), .ren_o(ren_o), .wbase_o(wbase_o), .rbase_o(rbase_o),
      .wr_idx_o(wr_idx_o), .rd_idx_o(rd_idx_o),
      .repeat_o(repeat_o), .drop_o(drop_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic aw_bursts(input int n);
      for (int k = 0; k < n; k++) begin
         aw_fire_i = 1'b1; tick();
      end
      aw_fire_i = 1'b0;
   endtask

   task automatic b_bursts(input int n, input int bad_at);
      for (int k = 0; k < n; k++) begin
         b_fire_i = 1'b1;
         bresp_i  = (k == bad_at) ? 2'b10 : 2'b00;
         tick();
      end
      b_fire_i = 1'b0;
      bresp_i  = 2'b00;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; vs_i = 1'b0; en_i = 1'b1;
      aw_fire_i = 1'b0; b_fire_i = 1'b0; bresp_i = 2'b00; ar_fire_i = 1'b0;
      tick(); tick();
      rst_ni = 1'b1;
      tick();
      checks++; if (wr_idx_o !== 3'd0) begin failures++; $display("FAIL reset_wr got=%0d exp=0", wr_idx_o); end
      checks++; if (rd_idx_o !== 3'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", rd_idx_o); end
      checks++; if (wbase_o !== BASE || rbase_o !== BASE) begin failures++; $display("FAIL reset_base got=%h/%h exp=%h", wbase_o, rbase_o, BASE); end
      checks++; if ({wen_o, ren_o, repeat_o, drop_o, err_o} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {wen_o, ren_o, repeat_o, drop_o, err_o}); end
   endtask

   task automatic test_first_frame();
      vs_i = 1'b1; tick();
      checks++; if (wen_o !== 1'b1 || wr_idx_o !== 3'd0) begin failures++; $display("FAIL start_wen got=%b/%0d exp=1/0", wen_o, wr_idx_o); end
      checks++; if (drop_o !== 1'b0 || repeat_o !== 1'b0) begin failures++; $display("FAIL start_pulses got=%b%b exp=00", drop_o, repeat_o); end
      vs_i = 1'b0;
      aw_bursts(NB);
      checks++; if (wen_o !== 1'b0) begin failures++; $display("FAIL aw_sat_wen got=%b exp=0", wen_o); end
      b_bursts(NB, -1);
      vs_i = 1'b1; tick();
      checks++; if (rd_idx_o !== 3'd0 || wr_idx_o !== 3'd1) begin failures++; $display("FAIL f1_idx got=rd%0d wr%0d exp=rd0 wr1", rd_idx_o, wr_idx_o); end
      checks++; if (ren_o !== 1'b1 || wen_o !== 1'b1) begin failures++; $display("FAIL f1_en got=%b%b exp=11", ren_o, wen_o); end
      checks++; if (drop_o !== 1'b0 || repeat_o !== 1'b0) begin failures++; $display("FAIL f1_pulses got=%b%b exp=00", drop_o, repeat_o); end
      checks++; if (wbase_o !== 32'h2000_0400 || rbase_o !== BASE) begin failures++; $display("FAIL f1_base got=%h/%h exp=20000400/%h", wbase_o, rbase_o, BASE); end
      vs_i = 1'b0; tick();
   endtask

   task automatic test_second_frame();
      for (int k = 0; k < NB; k++) begin
         ar_fire_i = 1'b1; tick();
      end
      ar_fire_i = 1'b0;
      checks++; if (ren_o !== 1'b0) begin failures++; $display("FAIL ar_sat_ren got=%b exp=0", ren_o); end
      aw_bursts(NB);
      b_bursts(NB, -1);
      vs_i = 1'b1; tick();
      checks++; if (rd_idx_o !== 3'd1 || wr_idx_o !== 3'd0) begin failures++; $display("FAIL f2_idx got=rd%0d wr%0d exp=rd1 wr0", rd_idx_o, wr_idx_o); end
      checks++; if (rbase_o !== 32'h2000_0400 || wbase_o !== BASE) begin failures++; $display("FAIL f2_base got=%h/%h exp=20000400/%h", rbase_o, wbase_o, BASE); end
      checks++; if (drop_o !== 1'b0 || repeat_o !== 1'b0 || ren_o !== 1'b1) begin failures++; $display("FAIL f2_flags got=%b%b%b exp=001", drop_o, repeat_o, ren_o); end
      vs_i = 1'b0; tick();
      checks++; if (drop_o !== 1'b0 || repeat_o !== 1'b0) begin failures++; $display("FAIL pulse_width got=%b%b exp=00", drop_o, repeat_o); end
   endtask

   task automatic test_short_frame();
      aw_bursts(NB);
      b_bursts(NB - 1, -1);
      vs_i = 1'b1; tick();
      checks++; if (repeat_o !== 1'b1 || drop_o !== 1'b1) begin failures++; $display("FAIL short_pulses got=rep%b drop%b exp=11", repeat_o, drop_o); end
      checks++; if (rd_idx_o !== 3'd1 || wr_idx_o !== 3'd0) begin failures++; $display("FAIL short_idx got=rd%0d wr%0d exp=rd1 wr0", rd_idx_o, wr_idx_o); end
      vs_i = 1'b0; tick();
   endtask

   task automatic test_bad_resp();
      aw_bursts(NB);
      b_bursts(NB, 3);
      checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err_o); end
      vs_i = 1'b1; tick();
      checks++; if (repeat_o !== 1'b1 || drop_o !== 1'b1) begin failures++; $display("FAIL bad_pulses got=rep%b drop%b exp=11", repeat_o, drop_o); end
      checks++; if (rd_idx_o !== 3'd1 || wr_idx_o !== 3'd0) begin failures++; $display("FAIL bad_idx got=rd%0d wr%0d exp=rd1 wr0", rd_idx_o, wr_idx_o); end
      vs_i = 1'b0; tick(); tick();
      checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err_o); end
   endtask

   task automatic test_last_b_on_vs();
      aw_bursts(NB);
      b_bursts(NB - 1, -1);
      vs_i = 1'b1; b_fire_i = 1'b1; tick();
      vs_i = 1'b0; b_fire_i = 1'b0;
      checks++; if (rd_idx_o !== 3'd0 || wr_idx_o !== 3'd1) begin failures++; $display("FAIL vsb_idx got=rd%0d wr%0d exp=rd0 wr1", rd_idx_o, wr_idx_o); end
      checks++; if (repeat_o !== 1'b0 || drop_o !== 1'b0) begin failures++; $display("FAIL vsb_pulses got=rep%b drop%b exp=00", repeat_o, drop_o); end
      tick();
   endtask

   task automatic test_enable_and_reset();
      aw_bursts(4);
      en_i = 1'b0; tick();
      checks++; if (wen_o !== 1'b0 || ren_o !== 1'b0) begin failures++; $display("FAIL en_off got=%b%b exp=00", wen_o, ren_o); end
      checks++; if (wr_idx_o !== 3'd1) begin failures++; $display("FAIL en_off_idx got=%0d exp=1", wr_idx_o); end
      en_i = 1'b1; tick();
      checks++; if (wen_o !== 1'b1 || ren_o !== 1'b1) begin failures++; $display("FAIL en_on got=%b%b exp=11", wen_o, ren_o); end
      aw_bursts(4);
      checks++; if (wen_o !== 1'b0) begin failures++; $display("FAIL en_kept_cnt got=%b exp=0", wen_o); end
      b_bursts(NB, -1);
      vs_i = 1'b1; tick();
      vs_i = 1'b0;
      checks++; if (rd_idx_o !== 3'd1 || wr_idx_o !== 3'd0) begin failures++; $display("FAIL en_frame_idx got=rd%0d wr%0d exp=rd1 wr0", rd_idx_o, wr_idx_o); end
      aw_bursts(2);
      #2 rst_ni = 1'b0;
      #1;
      checks++; if (wr_idx_o !== 3'd0 || rd_idx_o !== 3'd0 || rbase_o !== BASE) begin failures++; $display("FAIL async_idx got=wr%0d rd%0d rb=%h exp=0 0 %h", wr_idx_o, rd_idx_o, rbase_o, BASE); end
      checks++; if ({wen_o, ren_o, err_o} !== 3'b000) begin failures++; $display("FAIL async_flags got=%b exp=000", {wen_o, ren_o, err_o}); end
      tick();
      rst_ni = 1'b1;
      tick();
      checks++; if (wen_o !== 1'b0) begin failures++; $display("FAIL post_reset_wen got=%b exp=0", wen_o); end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_second_frame();
      test_short_frame();
      test_bad_resp();
      test_last_b_on_vs();
      test_enable_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
